polar_pkt_sequencer: RTL and testbench
======================================

// Module: polar_pkt_sequencer
// PURPOSE
//  Top-level controller for the SC polar decoder core. Walks the packet list in
//  the 192-bit input memory: count word, then per packet a header row and LLR
//  rows. Streams each packet's LLR rows to the core, starts it, and collects the
//  decoded bits. Writes one 140-bit result row per packet, then raises proc_done.
// PARAMETERS
//  MAX_PKT     44   max packets per run; a larger count is clamped
//  PKT_STRIDE  33   rows per packet: 1 header + 32 LLR rows (512 LLRs, 16/row)
//  RD_LAT      1    input-memory read latency in cycles (raddr -> rdata)
// PORTS
//  clk         in   1    clock, rising edge
//  rst         in   1    asynchronous, active-high reset
//  module_en   in   1    run request; level-sensitive, sampled in IDLE
//  proc_done   out  1    all packets written; held until module_en=0
//  raddr       out  11   input-memory row address
//  rdata       in   192  input-memory row; 16 x 12-bit LLRs, LLR0 in [11:0]
//  wr_en       out  1    result-memory write strobe, 1 cycle
//  waddr       out  6    result row = packet index
//  wdata       out  140  decoded bits, u_hat(info bit 0) in [0], upper bits 0
//  err         out  1    sticky: bad count or bad header seen this run
//  core_start  out  1    1-cycle pulse: packet loaded, start decoding
//  core_n      out  10   code length N of current packet (stable while busy)
//  core_k      out  8    info length K of current packet (stable while busy)
//  llr_valid   out  1    llr_data/llr_idx valid this cycle
//  llr_idx     out  5    LLR row index within packet, 0..N/16-1
//  llr_data    out  192  registered copy of rdata
//  core_done   in   1    1-cycle pulse from core: core_dec valid
//  core_dec    in   140  decoded info bits from core
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; packet counter p=0; err=0.
//  Address map: count P = row 0 bits[6:0]. Packet p base b = 1 + p*PKT_STRIDE.
//   Header row b: N = [9:0], K = [17:10]. LLR row r of packet p = b+1+r.
//  FSM states and transitions:
//  - IDLE: module_en=1 -> RD_CNT and clear err.
//  - RD_CNT: raddr=0. After RD_LAT, latch P.
//    P=0 -> DONE. P>MAX_PKT -> P=MAX_PKT and err=1.
//  - RD_HDR: raddr=b. After RD_LAT, latch N and K.
//    Valid header: N in {128,256,512}, 1<=K<=140, K<=N.
//    Invalid header -> WRITE with wdata=0 and err=1; the core is never started.
//  - LOAD: issue N/16 LLR addresses on consecutive cycles.
//    llr_valid goes high RD_LAT+1 cycles after each address (registered data).
//    llr_valid pulses are contiguous; llr_idx is 0..N/16-1 in order.
//  - START: core_start=1 for exactly 1 cycle, the cycle after the last llr_valid.
//  - WAIT: hold until core_done; latch core_dec with bits above K masked to 0.
//  - WRITE: wr_en=1 for 1 cycle with waddr=p. Then p+1==P -> DONE, else p++ and RD_HDR.
//  - DONE: proc_done=1; module_en=0 -> IDLE with proc_done=0 the next cycle.
//  Ordering: core_done is ignored outside WAIT. A core_done coincident with
//   core_start is ignored.
//  module_en deasserted mid-run: ignored; the run completes to DONE.
//  rst mid-run: immediate return to reset state; no partial write is committed.
//  Width: b fits in 11 bits (max 1+43*33+32 = 1452). p is a 6-bit counter with
//   no wrap, since P<=44.
//  Throughput: no idle cycles between states beyond RD_LAT bubbles.
// TESTING
//  1. P=1, N=128, K=64, core returns 0xA5.. pattern -> 8 llr_valid
//     (llr_idx 0..7, raddr 2..9); one core_start; wr_en, waddr=0; proc_done.
//  2. P=3 with N=512/256/128 -> raddr bases 1, 34, 67; 32/16/8 LLR rows;
//     waddr 0,1,2 in order.
//  3. P=0 -> proc_done 1+RD_LAT+1 cycles after module_en; no wr_en, no core_start.
//  4. Header N=100 or K=141 -> that row written as 0, err=1, no core_start;
//     the next packet decodes normally.
//  5. P=60 -> exactly 44 writes (waddr 0..43); err=1.
//  6. rst pulsed during WAIT -> all outputs 0, IDLE. Rerun with module_en
//     -> full correct run; stray core_done in IDLE has no effect.

Source files
------------

// File: rtl/polar_pkt_sequencer.sv
// polar_pkt_sequencer
//   Top-level controller for the SC polar decoder core. Reads the packet count
//   from input-memory row 0, then for every packet reads its header row,
//   streams its LLR rows to the core, starts the core, and collects the
//   decoded bits. One 140-bit result row is written per packet, after which
//   proc_done is raised until module_en drops.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   module_en       run request, sampled in IDLE
//   proc_done       run complete, held until module_en = 0
//   raddr / rdata   input-memory read port (RD_LAT cycles raddr -> rdata)
//   wr_en / waddr / wdata   result-memory write port (row = packet index)
//   err             sticky: bad packet count or bad header seen in this run
//   core_start      1-cycle start pulse to the decoder core
//   core_n, core_k  code / info length of the current packet
//   llr_valid, llr_idx, llr_data   LLR row stream to the core
//   core_done, core_dec            completion pulse and decoded bits from the core
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for module_en
// RD_CNT   | row 0 addressed; packet count latched once the read returns
// RD_HDR   | header row addressed; N/K latched and checked on return
// LOAD     | one LLR row address issued per cycle
// DRAIN    | waiting for the last LLR row to leave the read pipeline
// START    | core_start pulse
// WAIT     | waiting for core_done; decoded bits captured and masked to K
// WRITE    | result row written for the current packet
// DONE     | proc_done held until module_en is released

module polar_pkt_sequencer #(
    parameter int MAX_PKT    = 44,
    parameter int PKT_STRIDE = 33,
    parameter int RD_LAT     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         module_en,
    output logic         proc_done,
    output logic [10:0]  raddr,
    input  logic [191:0] rdata,
    output logic         wr_en,
    output logic [5:0]   waddr,
    output logic [139:0] wdata,
    output logic         err,
    output logic         core_start,
    output logic [9:0]   core_n,
    output logic [7:0]   core_k,
    output logic         llr_valid,
    output logic [4:0]   llr_idx,
    output logic [191:0] llr_data,
    input  logic         core_done,
    input  logic [139:0] core_dec
);

    localparam int LW = $clog2(RD_LAT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_CNT,
        S_RD_HDR,
        S_LOAD,
        S_DRAIN,
        S_START,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [LW-1:0]  lat_cnt;
    logic [5:0]     pkt_total;
    logic [5:0]     pkt_idx;
    logic [10:0]    base;
    logic [9:0]     n_reg;
    logic [7:0]     k_reg;
    logic [4:0]     issue_idx;
    logic [4:0]     out_idx;
    logic [RD_LAT:0] vld_pipe;
    logic [139:0]   res_reg;
    logic           err_reg;

    logic           rd_ready;
    logic [6:0]     cnt_in;
    logic [9:0]     hdr_n;
    logic [7:0]     hdr_k;
    logic           hdr_ok;
    logic [4:0]     last_row;
    logic           pkt_last;
    logic           llr_vld_i;
    logic [139:0]   k_mask;

    // Read data is usable when the latency down-counter reaches zero.
    assign rd_ready  = (lat_cnt == '0);
    assign cnt_in    = rdata[6:0];
    assign hdr_n     = rdata[9:0];
    assign hdr_k     = rdata[17:10];
    assign hdr_ok    = ((hdr_n == 10'd128) || (hdr_n == 10'd256) || (hdr_n == 10'd512))
                     && (hdr_k != 8'd0) && (hdr_k <= 8'd140)
                     && ({2'b00, hdr_k} <= hdr_n);

    // N/16 - 1 in 5 bits; for N=512 the field n[8:4] is 0 and wraps to 31.
    assign last_row  = n_reg[8:4] - 5'd1;
    assign pkt_last  = ((pkt_idx + 6'd1) == pkt_total);
    assign llr_vld_i = vld_pipe[RD_LAT];

    always_comb begin
        k_mask = '0;
        for (int i = 0; i < 140; i++) begin
            k_mask[i] = (8'(i) < k_reg);
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (module_en) state_nxt = S_RD_CNT;
            end
            S_RD_CNT: begin
                if (rd_ready) state_nxt = (cnt_in == 7'd0) ? S_DONE : S_RD_HDR;
            end
            S_RD_HDR: begin
                if (rd_ready) state_nxt = hdr_ok ? S_LOAD : S_WRITE;
            end
            S_LOAD: begin
                if (issue_idx == last_row) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (llr_vld_i && (out_idx == last_row)) state_nxt = S_START;
            end
            S_START: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                state_nxt = pkt_last ? S_DONE : S_RD_HDR;
            end
            S_DONE: begin
                if (!module_en) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt   <= '0;
            pkt_total <= '0;
            pkt_idx   <= '0;
            base      <= '0;
            n_reg     <= '0;
            k_reg     <= '0;
            issue_idx <= '0;
            out_idx   <= '0;
            vld_pipe  <= '0;
            res_reg   <= '0;
            err_reg   <= 1'b0;
            llr_data  <= '0;
        end else begin
            // Reload the read-latency timer on every state change; it only
            // matters in the two read states.
            if (state_nxt != state) begin
                lat_cnt <= LW'(RD_LAT);
            end else if (lat_cnt != '0) begin
                lat_cnt <= lat_cnt - LW'(1);
            end

            // Issued addresses travel RD_LAT cycles to rdata plus one register.
            vld_pipe <= {vld_pipe[RD_LAT-1:0], (state == S_LOAD)};
            if (vld_pipe[RD_LAT-1]) llr_data <= rdata;
            if (llr_vld_i) out_idx <= out_idx + 5'd1;

            case (state)
                S_IDLE: begin
                    if (module_en) begin
                        err_reg <= 1'b0;
                        pkt_idx <= '0;
                        base    <= 11'd1;
                    end
                end
                S_RD_CNT: begin
                    if (rd_ready) begin
                        if (cnt_in > 7'(MAX_PKT)) begin
                            pkt_total <= 6'(MAX_PKT);
                            err_reg   <= 1'b1;
                        end else begin
                            pkt_total <= cnt_in[5:0];
                        end
                    end
                end
                S_RD_HDR: begin
                    if (rd_ready) begin
                        n_reg     <= hdr_n;
                        k_reg     <= hdr_k;
                        issue_idx <= '0;
                        out_idx   <= '0;
                        res_reg   <= '0;
                        if (!hdr_ok) err_reg <= 1'b1;
                    end
                end
                S_LOAD: begin
                    issue_idx <= issue_idx + 5'd1;
                end
                S_WAIT: begin
                    if (core_done) res_reg <= core_dec & k_mask;
                end
                S_WRITE: begin
                    if (!pkt_last) begin
                        pkt_idx <= pkt_idx + 6'd1;
                        base    <= base + 11'(PKT_STRIDE);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic
    always_comb begin
        raddr      = '0;
        wr_en      = 1'b0;
        waddr      = '0;
        wdata      = '0;
        proc_done  = 1'b0;
        core_start = 1'b0;
        case (state)
            S_RD_HDR: raddr = base;
            S_LOAD:   raddr = base + 11'd1 + {6'd0, issue_idx};
            S_START:  core_start = 1'b1;
            S_WRITE: begin
                wr_en = 1'b1;
                waddr = pkt_idx;
                wdata = res_reg;
            end
            S_DONE:   proc_done = 1'b1;
            default: ;
        endcase
        llr_valid = llr_vld_i;
        llr_idx   = llr_vld_i ? out_idx : 5'd0;
    end

    assign err    = err_reg;
    assign core_n = n_reg;
    assign core_k = k_reg;

endmodule

// File: tb/tb_polar_pkt_sequencer.sv
// tb_polar_pkt_sequencer
//   Directed bench for polar_pkt_sequencer. A memory model with one cycle of
//   read latency holds the packet list; a core model answers core_start with
//   a known bit pattern. Expected result rows, LLR rows and core start
//   parameters are queued when a run is built and popped as the DUT emits them.

module tb_polar_pkt_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         module_en;
    logic         proc_done;
    logic [10:0]  raddr;
    logic [191:0] rdata;
    logic         wr_en;
    logic [5:0]   waddr;
    logic [139:0] wdata;
    logic         err;
    logic         core_start;
    logic [9:0]   core_n;
    logic [7:0]   core_k;
    logic         llr_valid;
    logic [4:0]   llr_idx;
    logic [191:0] llr_data;
    logic         core_done;
    logic [139:0] core_dec;

    logic         cd_m = 1'b0;
    logic [139:0] cdec_m = '0;
    logic         stray_done;
    logic         stray_on_start;
    int           core_delay;
    logic [7:0]   kk_m;

    int checks = 0;
    int errors = 0;

    logic [191:0] mem [0:2047];
    int hn [0:63];
    int hk [0:63];

    typedef struct packed { logic [5:0] addr; logic [139:0] data; } wr_t;
    typedef struct packed { logic [4:0] idx; logic [191:0] data; } llr_t;
    typedef struct packed { logic [9:0] n; logic [7:0] k; } hdr_t;

    wr_t  wr_q [$];
    llr_t llr_q [$];
    hdr_t start_q [$];

    polar_pkt_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .module_en  (module_en),
        .proc_done  (proc_done),
        .raddr      (raddr),
        .rdata      (rdata),
        .wr_en      (wr_en),
        .waddr      (waddr),
        .wdata      (wdata),
        .err        (err),
        .core_start (core_start),
        .core_n     (core_n),
        .core_k     (core_k),
        .llr_valid  (llr_valid),
        .llr_idx    (llr_idx),
        .llr_data   (llr_data),
        .core_done  (core_done),
        .core_dec   (core_dec)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rdata <= mem[raddr];

    assign core_done = cd_m | stray_done;
    assign core_dec  = stray_done ? {140{1'b1}} : cdec_m;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [139:0] core_pat(input logic [7:0] k);
        logic [139:0] v;
        logic [7:0]   a5;
        a5 = 8'hA5;
        for (int i = 0; i < 140; i++) v[i] = a5[i % 8];
        v[7:0] = v[7:0] ^ k;
        return v;
    endfunction

    function automatic logic [139:0] exp_bits(input logic [7:0] k);
        logic [139:0] v;
        v = core_pat(k);
        for (int i = 0; i < 140; i++) if (i >= int'(k)) v[i] = 1'b0;
        return v;
    endfunction

    function automatic logic [191:0] rnd192();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [191:0] all_out();
        return 192'({proc_done, raddr, wr_en, waddr, wdata, err, core_start,
                     core_n, core_k, llr_valid, llr_idx});
    endfunction

    // Core model: answers each core_start after core_delay cycles. With
    // stray_on_start set it also raises core_done during the start cycle.
    always begin
        @(negedge clk);
        if (!rst && core_start) begin
            kk_m = core_k;
            if (stray_on_start) begin
                cd_m   = 1'b1;
                cdec_m = {140{1'b1}};
                @(negedge clk);
                cd_m   = 1'b0;
                cdec_m = '0;
            end
            repeat (core_delay) @(negedge clk);
            cdec_m = core_pat(kk_m);
            cd_m   = 1'b1;
            @(negedge clk);
            cd_m   = 1'b0;
            cdec_m = '0;
        end
    end

    // Output monitor
    logic prev_v = 1'b0;
    wr_t  we;
    llr_t le;
    hdr_t he;

    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (llr_valid) begin
                chk("llr_expected", 192'(llr_q.size() != 0), 192'd1);
                if (llr_q.size() != 0) begin
                    le = llr_q.pop_front();
                    chk("llr_idx", 192'(llr_idx), 192'(le.idx));
                    chk("llr_data", llr_data, le.data);
                end
                if (llr_idx != 5'd0) chk("llr_contiguous", 192'(prev_v), 192'd1);
            end
            if (core_start) begin
                chk("start_expected", 192'(start_q.size() != 0), 192'd1);
                chk("start_after_last_llr", 192'(prev_v), 192'd1);
                if (start_q.size() != 0) begin
                    he = start_q.pop_front();
                    chk("core_n", 192'(core_n), 192'(he.n));
                    chk("core_k", 192'(core_k), 192'(he.k));
                end
            end
            if (wr_en) begin
                chk("wr_expected", 192'(wr_q.size() != 0), 192'd1);
                if (wr_q.size() != 0) begin
                    we = wr_q.pop_front();
                    chk("waddr", 192'(waddr), 192'(we.addr));
                    chk("wdata", 192'(wdata), 192'(we.data));
                end
            end
            prev_v = llr_valid;
        end
    end

    // Builds the memory image for a run of pr packets from hn/hk and queues
    // every expected DUT output.
    task automatic build(input int pr, output logic exp_e);
        int pe;
        int b;
        logic [191:0] junk;
        logic [9:0]   n10;
        logic [7:0]   k8;
        logic         ok;
        exp_e = (pr > 44);
        pe    = (pr > 44) ? 44 : pr;
        junk  = rnd192();
        mem[0] = {junk[191:7], 7'(pr)};
        for (int p = 0; p < pe; p++) begin
            b    = 1 + p * 33;
            n10  = 10'(hn[p]);
            k8   = 8'(hk[p]);
            junk = rnd192();
            mem[b] = {junk[191:18], k8, n10};
            ok = ((hn[p] == 128) || (hn[p] == 256) || (hn[p] == 512))
               && (hk[p] >= 1) && (hk[p] <= 140) && (hk[p] <= hn[p]);
            if (ok) begin
                start_q.push_back('{n: n10, k: k8});
                for (int r = 0; r < hn[p] / 16; r++) begin
                    mem[b + 1 + r] = rnd192();
                    llr_q.push_back('{idx: 5'(r), data: mem[b + 1 + r]});
                end
                wr_q.push_back('{addr: 6'(p), data: exp_bits(k8)});
            end else begin
                exp_e = 1'b1;
                wr_q.push_back('{addr: 6'(p), data: 140'd0});
            end
        end
    endtask

    task automatic run(input string tag, input logic exp_e, input int exp_lat);
        int n;
        @(posedge clk);
        #1;
        module_en = 1'b1;
        n = 0;
        while (proc_done !== 1'b1 && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_done_seen"}, 192'(n < 20000), 192'd1);
        if (exp_lat >= 0) chk({tag, "_done_latency"}, 192'(n), 192'(exp_lat));
        chk({tag, "_err"}, 192'(err), 192'(exp_e));
        chk({tag, "_wr_left"}, 192'(wr_q.size()), 192'd0);
        chk({tag, "_llr_left"}, 192'(llr_q.size()), 192'd0);
        chk({tag, "_start_left"}, 192'(start_q.size()), 192'd0);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_done_held"}, 192'(proc_done), 192'd1);
        module_en = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_done_clear"}, 192'(proc_done), 192'd0);
    endtask

    initial begin
        logic e;
        int   n;
        rst            = 1'b1;
        module_en      = 1'b0;
        stray_done     = 1'b0;
        stray_on_start = 1'b0;
        core_delay     = 4;
        for (int i = 0; i < 2048; i++) mem[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_out(), 192'd0);
        chk("reset_llr_data", llr_data, 192'd0);
        rst = 1'b0;

        // 1: single packet N=128, K=64
        hn[0] = 128; hk[0] = 64;
        build(1, e);
        run("t1", e, -1);

        // 2: three packets of decreasing N; core_done also pulsed with core_start
        hn[0] = 512; hk[0] = 140;
        hn[1] = 256; hk[1] = 100;
        hn[2] = 128; hk[2] = 1;
        stray_on_start = 1'b1;
        build(3, e);
        run("t2", e, -1);
        stray_on_start = 1'b0;

        // 3: empty packet list
        build(0, e);
        run("t3", e, 3);

        // 4: mix of bad and good headers
        hn[0] = 100; hk[0] = 10;
        hn[1] = 128; hk[1] = 128;
        hn[2] = 256; hk[2] = 141;
        hn[3] = 128; hk[3] = 129;
        hn[4] = 512; hk[4] = 0;
        hn[5] = 128; hk[5] = 5;
        build(6, e);
        run("t4", e, -1);

        // 5: packet count above the limit is clamped
        for (int p = 0; p < 64; p++) begin
            hn[p] = 128;
            hk[p] = 32 + (p % 7);
        end
        build(60, e);
        run("t5", e, -1);

        // 6: reset while the core is busy, stray core_done in IDLE, then rerun
        hn[0] = 128; hk[0] = 50;
        hn[1] = 256; hk[1] = 77;
        core_delay = 20;
        build(2, e);
        @(posedge clk);
        #1;
        module_en = 1'b1;
        n = 0;
        while (core_start !== 1'b1 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6_start_seen", 192'(n < 500), 192'd1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_outputs", all_out(), 192'd0);
        chk("t6_rst_llr_data", llr_data, 192'd0);
        wr_q.delete();
        llr_q.delete();
        start_q.delete();
        module_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        stray_done = 1'b1;
        @(posedge clk);
        #1;
        stray_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_idle_after_stray", all_out(), 192'd0);
        core_delay = 3;
        build(2, e);
        run("t6_rerun", e, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
